// File: rtl/sens_temp_sched.sv
// sens_temp_sched: round-robin scheduler sharing one temperature converter among NSENS sensor channels.
// Optional WAIT watchdog is enabled by defining SENS_TEMP_SCHED_TIMEOUT_EN.
module sens_temp_sched #(
  parameter int NSENS       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NSENS-1:0]      i_req,
  input  logic [16*NSENS-1:0]   i_sens_din,
  input  logic [11:0]           i_conv_dout,
  input  logic                  i_conv_done,
  output logic [15:0]           o_conv_din,
  output logic                  o_conv_startp,
  output logic [12*NSENS-1:0]   o_res_dout,
  output logic [NSENS-1:0]      o_res_upd,
  output logic [NSENS-1:0]      o_ovr,
  output logic                  o_busy,
  output logic                  o_tmo_err
);

  localparam int             PW    = (NSENS > 1) ? $clog2(NSENS) : 1;
  localparam logic [PW:0]    LP_NS = (PW+1)'(NSENS);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t            r_state;
  logic [15:0]       r_hold [NSENS];
  logic [11:0]       r_res  [NSENS];
  logic [NSENS-1:0]  r_pend;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_g;
  logic [15:0]       r_conv_din;
  logic              r_startp;
  logic [NSENS-1:0]  r_res_upd;
  logic [NSENS-1:0]  r_ovr;

  logic              w_found;
  logic [PW-1:0]     w_sel;
  logic [PW:0]       w_idx;
  logic              w_gnt_vld;
  logic [NSENS-1:0]  w_gnt;

`ifdef SENS_TEMP_SCHED_TIMEOUT_EN
  localparam int           TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] LP_TCMAX = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0]     r_tcnt;
  logic              r_tmo_err;
  assign o_tmo_err = r_tmo_err;
`else
  logic              w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYC < 0);
  assign o_tmo_err    = 1'b0;
`endif

  // Search starts one past the last grant and wraps, giving strict round-robin order.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NSENS; k++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_idx >= LP_NS) w_idx = w_idx - LP_NS;
      if (!w_found && r_pend[w_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[PW-1:0];
      end
    end
  end

  assign w_gnt_vld = (r_state == S_IDLE) && w_found;
  assign w_gnt     = w_gnt_vld ? (NSENS'(1) << w_sel) : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_pend     <= '0;
      r_ptr      <= PW'(NSENS - 1);
      r_g        <= '0;
      r_conv_din <= '0;
      r_startp   <= 1'b0;
      r_res_upd  <= '0;
      r_ovr      <= '0;
      for (int i = 0; i < NSENS; i++) begin
        r_hold[i] <= '0;
        r_res[i]  <= '0;
      end
`ifdef SENS_TEMP_SCHED_TIMEOUT_EN
      r_tcnt    <= '0;
      r_tmo_err <= 1'b0;
`endif
    end else begin
      r_startp  <= 1'b0;
      r_res_upd <= '0;
`ifdef SENS_TEMP_SCHED_TIMEOUT_EN
      r_tmo_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_g        <= w_sel;
            r_ptr      <= w_sel;
            r_conv_din <= r_hold[w_sel];
            r_startp   <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          r_state <= S_WAIT;
`ifdef SENS_TEMP_SCHED_TIMEOUT_EN
          r_tcnt  <= '0;
`endif
        end
        S_WAIT: begin
          if (i_conv_done) begin
            r_res[r_g]     <= i_conv_dout;
            r_res_upd[r_g] <= 1'b1;
            r_state        <= S_IDLE;
          end
`ifdef SENS_TEMP_SCHED_TIMEOUT_EN
          else if (r_tcnt == LP_TCMAX) begin
            r_tmo_err <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase

      // A new sample on the channel being granted refills hold and keeps it pending.
      for (int i = 0; i < NSENS; i++) begin
        r_ovr[i] <= i_req[i] & r_pend[i] & ~w_gnt[i];
        if (i_req[i]) begin
          r_hold[i] <= i_sens_din[16*i +: 16];
          r_pend[i] <= 1'b1;
        end else if (w_gnt[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NSENS; gi++) begin : g_res
    assign o_res_dout[12*gi +: 12] = r_res[gi];
  end

  assign o_conv_din    = r_conv_din;
  assign o_conv_startp = r_startp;
  assign o_res_upd     = r_res_upd;
  assign o_ovr         = r_ovr;
  assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_sens_temp_sched.sv
// Testbench for sens_temp_sched: stand-in converter, transaction-level reference model,
// directed vector table, hand-written corner sequences and a randomized phase.
module tb_sens_temp_sched;
  localparam int N  = 4;
  localparam int TC = 8;
`ifdef SENS_TEMP_SCHED_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [16*N-1:0] sens_din;
  logic [11:0]     conv_dout;
  logic            conv_done;
  logic [15:0]     o_conv_din;
  logic            o_conv_startp;
  logic [12*N-1:0] o_res_dout;
  logic [N-1:0]    o_res_upd;
  logic [N-1:0]    o_ovr;
  logic            o_busy;
  logic            o_tmo_err;

  always #5 clk = ~clk;

  sens_temp_sched #(.NSENS(N), .TIMEOUT_CYC(TC)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_sens_din(sens_din),
    .i_conv_dout(conv_dout), .i_conv_done(conv_done),
    .o_conv_din(o_conv_din), .o_conv_startp(o_conv_startp), .o_res_dout(o_res_dout),
    .o_res_upd(o_res_upd), .o_ovr(o_ovr), .o_busy(o_busy), .o_tmo_err(o_tmo_err)
  );

  logic [79:0] w_dut;
  assign w_dut = {5'b0, o_conv_startp, o_conv_din, o_res_upd, o_ovr, o_busy, o_tmo_err, o_res_dout};

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  // Stand-in converter: clamp(1251 + x/8) with a configurable latency.
  function automatic logic [11:0] conv_f(input logic [15:0] x);
    int v;
    v = 1251 + ($signed(x) >>> 3);
    if (v < 0) v = 0;
    if (v > 4095) v = 4095;
    return 12'(v);
  endfunction

  bit          cv_stall = 1'b0;
  bit          cv_rand  = 1'b0;
  bit          cv_spur  = 1'b0;
  int          cv_lat_fix = 2;
  int          cv_cnt = 0;
  logic [15:0] cv_din = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        conv_done = 1'b0;
        cv_cnt    = 0;
      end else begin
        conv_done = 1'b0;
        if (o_conv_startp) begin
          cv_din = o_conv_din;
          cv_cnt = cv_rand ? int'($urandom_range(1, 5)) : cv_lat_fix;
        end else if (cv_cnt > 0) begin
          cv_cnt--;
          if (cv_cnt == 0 && !cv_stall) begin
            conv_done = 1'b1;
            conv_dout = conv_f(cv_din);
          end
        end else if (cv_spur && $urandom_range(0, 7) == 0) begin
          conv_done = 1'b1;
          conv_dout = 12'($urandom);
        end
      end
    end
  end

  // Reference model: set of pending channels with their latest sample, one conversion in flight.
  bit [N-1:0]  m_pend;
  logic [15:0] m_hold [N];
  logic [11:0] m_res  [N];
  int          m_last, m_cur, m_age, m_gnt;
  bit          m_idle;
  logic        e_start, e_tmo;
  logic [15:0] e_din;
  logic [N-1:0] e_upd, e_ovr;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pend = '0;
        for (int i = 0; i < N; i++) begin
          m_hold[i] = '0;
          m_res[i]  = '0;
        end
        m_last = N - 1; m_cur = -1; m_age = 0;
        e_start = 1'b0; e_din = '0; e_upd = '0; e_ovr = '0; e_tmo = 1'b0;
      end else begin
        e_start = 1'b0; e_upd = '0; e_ovr = '0; e_tmo = 1'b0;
        m_idle = (m_cur < 0);
        if (!m_idle) begin
          if (m_age >= 1 && conv_done) begin
            m_res[m_cur] = conv_dout;
            e_upd[m_cur] = 1'b1;
            m_cur = -1;
          end else if (TMO_ON && m_age == TC) begin
            e_tmo = 1'b1;
            m_cur = -1;
          end else begin
            m_age++;
          end
        end
        m_gnt = -1;
        if (m_idle) begin
          for (int k = 1; k <= N; k++) begin
            if (m_gnt < 0 && m_pend[(m_last + k) % N]) m_gnt = (m_last + k) % N;
          end
        end
        for (int i = 0; i < N; i++)
          if (req[i] && m_pend[i] && i != m_gnt) e_ovr[i] = 1'b1;
        if (m_gnt >= 0) begin
          e_din = m_hold[m_gnt];
          m_pend[m_gnt] = 1'b0;
          m_last = m_gnt; m_cur = m_gnt; m_age = 0;
          e_start = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
          if (req[i]) begin
            m_hold[i] = sens_din[16*i +: 16];
            m_pend[i] = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("model", w_dut, {5'b0, e_start, e_din, e_upd, e_ovr, (m_cur >= 0), e_tmo,
                           m_res[3], m_res[2], m_res[1], m_res[0]});
    end
  end

  logic [15:0] q_din [$];
  int          q_upd [$];
  int          ovr_cnt [N];
  int          tmo_cnt = 0;
  int          cyc = 0;
  int          t_start = 0;
  int          t_tmo = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (o_conv_startp) begin
        q_din.push_back(o_conv_din);
        t_start = cyc;
      end
      for (int i = 0; i < N; i++) begin
        if (o_res_upd[i]) q_upd.push_back(i);
        if (o_ovr[i]) ovr_cnt[i]++;
      end
      if (o_tmo_err) begin
        tmo_cnt++;
        t_tmo = cyc;
      end
    end
  end

  task automatic clr();
    q_din.delete();
    q_upd.delete();
    for (int i = 0; i < N; i++) ovr_cnt[i] = 0;
    tmo_cnt = 0;
  endtask

  task automatic drive1(input int ch, input logic [15:0] v);
    req = '0;
    req[ch] = 1'b1;
    sens_din[16*ch +: 16] = v;
    @(negedge clk);
    req = '0;
  endtask

  task automatic wait_upd(input int n, input string nm);
    int c;
    c = 0;
    while (q_upd.size() < n && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk(nm, q_upd.size(), n);
  endtask

  typedef struct {
    int          ch;
    logic [15:0] smp;
    logic [11:0] res;
  } vec_t;
  vec_t vt [6];

  int          ord;
  int          ovr_tot;
  logic [11:0] exp_r3;

  initial begin
    vt[0] = '{0, 16'h0000, 12'h4E3};
    vt[1] = '{1, 16'h7FFF, 12'hFFF};
    vt[2] = '{2, 16'h8000, 12'h000};
    vt[3] = '{0, 16'hFFF8, 12'h4E2};
    vt[4] = '{2, 16'h0800, 12'h5E3};
    vt[5] = '{3, 16'h0100, 12'h503};

    rst_n = 1'b0; req = '0; sens_din = '0; conv_dout = '0; conv_done = 1'b0;
    clr();
    repeat (3) @(negedge clk);
    chk("reset_outputs", w_dut, 80'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      clr();
      drive1(vt[i].ch, vt[i].smp);
      wait_upd(1, "vec_done");
      repeat (3) @(negedge clk);
      chk("vec_upd_ch", q_upd[0], vt[i].ch);
      chk("vec_upd_single", q_upd.size(), 1);
      chk("vec_startp_single", q_din.size(), 1);
      chk("vec_conv_din", q_din[0], vt[i].smp);
      chk("vec_res", o_res_dout[12*vt[i].ch +: 12], vt[i].res);
    end

    clr();
    req = 4'hF;
    sens_din = {16'h0300, 16'h0200, 16'h0100, 16'h0000};
    @(negedge clk);
    req = '0;
    wait_upd(4, "rr4_done");
    ord = 0;
    for (int i = 0; i < q_upd.size(); i++) ord = (ord << 4) | q_upd[i];
    chk("rr4_order", ord, 32'h0123);
    clr();
    req = 4'b0011;
    sens_din[31:0] = {16'h0011, 16'h0010};
    @(negedge clk);
    req = '0;
    wait_upd(2, "rr2_done");
    chk("rr2_order", {q_upd[0][3:0], q_upd[1][3:0]}, 8'h01);
    repeat (3) @(negedge clk);

    clr();
    cv_lat_fix = 6;
    drive1(0, 16'h1234);
    drive1(2, 16'h7000);
    drive1(2, 16'h0040);
    wait_upd(2, "ovr_done");
    repeat (3) @(negedge clk);
    chk("ovr_pulse", ovr_cnt[2], 1);
    chk("ovr_other", ovr_cnt[0] + ovr_cnt[1] + ovr_cnt[3], 0);
    chk("ovr_din", {q_din[0], q_din[1]}, 32'h1234_0040);
    chk("ovr_res", o_res_dout[35:24], 12'h4EB);
    cv_lat_fix = 2;

    clr();
    drive1(1, 16'h0000);
    drive1(1, 16'h7FFF);
    wait_upd(2, "regrant_done");
    repeat (3) @(negedge clk);
    chk("regrant_din", {q_din[0], q_din[1]}, 32'h0000_7FFF);
    chk("regrant_ch", {q_upd[0][3:0], q_upd[1][3:0]}, 8'h11);
    ovr_tot = ovr_cnt[0] + ovr_cnt[1] + ovr_cnt[2] + ovr_cnt[3];
    chk("regrant_no_ovr", ovr_tot, 0);
    chk("regrant_res", o_res_dout[23:12], 12'hFFF);

    cv_rand = 1'b1;
    cv_spur = 1'b1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) req[i] = ($urandom_range(0, 7) == 0);
      sens_din = {$urandom, $urandom};
      @(negedge clk);
    end
    req = '0;
    cv_spur = 1'b0;
    repeat (60) @(negedge clk);
    chk("rand_drain_idle", o_busy, 1'b0);
    cv_rand = 1'b0;

    clr();
    cv_stall = 1'b1;
    exp_r3 = m_res[3];
    drive1(3, 16'h0200);
`ifdef SENS_TEMP_SCHED_TIMEOUT_EN
    repeat (20) @(negedge clk);
    chk("tmo_pulse", tmo_cnt, 1);
    chk("tmo_latency", t_tmo - t_start, 9);
    chk("tmo_idle", o_busy, 1'b0);
    chk("tmo_no_upd", q_upd.size(), 0);
    chk("tmo_res_kept", o_res_dout[47:36], exp_r3);
    chk("tmo_no_retry", q_din.size(), 1);
    drive1(3, 16'h0300);
    repeat (4) @(negedge clk);
`else
    repeat (40) @(negedge clk);
    chk("hold_busy", o_busy, 1'b1);
    chk("hold_no_tmo", tmo_cnt, 0);
    chk("hold_no_upd", q_upd.size(), 0);
    chk("hold_res_kept", o_res_dout[47:36], exp_r3);
`endif
    chk("rst_pre_busy", o_busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_zero", w_dut, 80'h0);
    cv_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    clr();
    drive1(0, 16'h0000);
    wait_upd(1, "post_rst_done");
    repeat (2) @(negedge clk);
    chk("post_rst_ch", q_upd[0], 0);
    chk("post_rst_res", o_res_dout, 48'h0000_0000_04E3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
